ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage. Sits directly upstream of the instruction decoder: holds the PC,
//  fetches one word from instruction memory over a req/ack handshake, and presents the
//  instruction to decode (Op = if_instr[31:26], Funct = if_instr[5:0]). It consumes the
//  decoder's 2-bit NPCOp to compute the next PC, so the core runs non-pipelined, one
//  instruction in flight.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC after reset; bits [1:0] must be 0
// PORTS
//  clk          in   1   clock, all state updates on the rising edge
//  rstn         in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  32  fetch address, equal to the current PC
//  imem_ack     in   1   memory accepts and returns data this cycle (same-cycle ack allowed)
//  imem_rdata   in   32  instruction word, sampled when imem_req & imem_ack
//  if_valid     out  1   if_instr/if_pc hold a valid instruction for decode
//  if_ready     in   1   decode retires the instruction; npc_op/rs_data are valid this cycle
//  if_instr     out  32  instruction register
//  if_pc        out  32  PC of if_instr
//  npc_op       in   2   00 PC+4, 01 branch, 10 jump (j/jal), 11 register (jr/jalr)
//  rs_data      in   32  GPR[rs] value, used when npc_op = 11
//  fetch_err    out  1   sticky: misaligned next PC detected
//  retire_cnt   out  32  number of retired instructions
// BEHAVIOUR
//  Reset (asynchronous, rstn=0): state IDLE, pc=RESET_PC, imem_req=0, if_valid=0,
//   if_instr=0, if_pc=RESET_PC, fetch_err=0, retire_cnt=0. imem_addr follows pc.
//  FSM states and transitions:
//   IDLE  -> FETCH unconditionally on the next edge (first edge after rstn rises).
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack: if_instr<=imem_rdata, if_pc<=pc, -> VALID.
//          Without ack: stay in FETCH, with req and addr held stable.
//   VALID: if_valid=1. The instruction is held until if_ready. On if_ready: pc<=npc,
//          retire_cnt<=retire_cnt+1 (wraps 32'hFFFF_FFFF->0), then -> FETCH, or -> ERR
//          if npc[1:0]!=0.
//   ERR:   fetch_err=1, imem_req=0, if_valid=0; held until reset. In the ERR transition,
//          pc still loads the bad npc for debug, and retire_cnt still increments.
//  Next-PC, with p4 = if_pc + 32'd4 (mod 2^32):
//   00: p4
//   01: p4 + {{14{if_instr[15]}}, if_instr[15:0], 2'b00}
//   10: {p4[31:28], if_instr[25:0], 2'b00}
//   11: rs_data
//  Branch taken/not-taken is already folded into npc_op by the decoder; this block does
//   not look at Zero.
//  Timing: minimum 2 cycles per instruction (FETCH with same-cycle ack, then VALID with
//   if_ready). imem latency adds cycles in FETCH; decode stall adds cycles in VALID.
//  if_ready outside VALID is ignored. imem_ack outside FETCH is ignored.
//  if_instr and if_pc change only on the FETCH->VALID edge.
//  Reset asserted mid-fetch or mid-VALID drops imem_req and if_valid immediately, with
//   no wait for the clock.
// TESTING
//  1. Reset release, imem_ack tied 1, mem[0]=32'h2008_0005, if_ready=1 with npc_op=00:
//     imem_req is 0 during reset, addr 0 fetched; if_valid from cycle 2; next fetch 0x4;
//     retire_cnt=1.
//  2. Memory ack delayed 3 cycles: imem_req and imem_addr=0x4 stay stable for 3 cycles;
//     if_valid stays 0 until the ack edge; then if_instr=rdata.
//  3. if_pc=0x10, if_instr=32'h1000_FFFE, npc_op=01 -> next imem_addr=0x0C
//     (0x14 + -8). Same instruction with npc_op=00 -> 0x14.
//  4. if_pc=0xF000_0000, instr=32'h0800_0040, npc_op=10 -> addr 0xF000_0100.
//     npc_op=11 with rs_data=0x0000_0200 -> addr 0x200.
//  5. npc_op=11, rs_data=0x0000_0202 -> fetch_err=1, imem_req=0, if_valid=0; stays set
//     until rstn=0.
//  6. Hold if_ready=0 for 5 cycles in VALID: if_instr/if_pc stable, no imem_req. Assert
//     rstn=0 mid-FETCH: outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, next-PC select
// One instruction in flight: IDLE -> FETCH -> VALID -> FETCH ..., ERR on misaligned next PC.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    output logic        fetch_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] npc;
    logic        fetch_done;
    logic        retire;

    assign fetch_done = (state == FETCH) && imem_ack;
    assign retire     = (state == VALID) && if_ready;
    assign p4         = if_pc + 32'd4;
    assign imem_addr  = pc;

    always_comb begin
        npc = p4;
        case (npc_op)
            2'b00: npc = p4;
            2'b01: npc = p4 + {{14{if_instr[15]}}, if_instr[15:0], 2'b00};
            2'b10: npc = {p4[31:28], if_instr[25:0], 2'b00};
            2'b11: npc = rs_data;
            default: npc = p4;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: if (imem_ack) state_nxt = VALID;
            VALID: if (if_ready) state_nxt = (npc[1:0] != 2'b00) ? ERR : FETCH;
            ERR:   state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so an async reset drops them at once.
    always_comb begin
        imem_req  = 1'b0;
        if_valid  = 1'b0;
        fetch_err = 1'b0;
        case (state)
            FETCH:   imem_req  = 1'b1;
            VALID:   if_valid  = 1'b1;
            ERR:     fetch_err = 1'b1;
            default: ;
        endcase
    end

    // On a misaligned npc the PC still loads it so the faulting target is visible on imem_addr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= RESET_PC;
            if_instr   <= 32'h0;
            if_pc      <= RESET_PC;
            retire_cnt <= 32'h0;
        end else begin
            if (fetch_done) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end
            if (retire) begin
                pc         <= npc;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with directed next-PC vectors
module tb_ifetch_unit;

    logic        clk;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [1:0]  npc_op;
    logic [31:0] rs_data;
    logic        fetch_err;
    logic [31:0] retire_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .npc_op     (npc_op),
        .rs_data    (rs_data),
        .fetch_err  (fetch_err),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_rd = 32'h2008_0005;
            32'h0000_0004: mem_rd = 32'h2009_0007;
            32'h0000_000C: mem_rd = 32'h2010_000C;
            32'h0000_0010: mem_rd = 32'h1000_FFFE;
            32'h0000_0014: mem_rd = 32'h2014_0014;
            32'hF000_0000: mem_rd = 32'h0800_0040;
            32'hF000_0100: mem_rd = 32'h0000_0008;
            32'h0000_0200: mem_rd = 32'h0000_0009;
            default:       mem_rd = 32'h0000_0000;
        endcase
    endfunction

    assign imem_rdata = mem_rd(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted fetch and every newly valid instruction is matched to the scoreboard.
    logic [31:0] pend_instr;
    logic [31:0] pend_pc;
    logic        pend;
    logic        prev_valid;
    initial begin
        pend = 1'b0;
        prev_valid = 1'b0;
        pend_instr = '0;
        pend_pc = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_valid = 1'b0;
                pend = 1'b0;
            end else begin
                if (if_valid && !prev_valid) begin
                    if (!pend) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        chk("if_pc", if_pc, pend_pc);
                        chk("if_instr", if_instr, pend_instr);
                        pend = 1'b0;
                    end
                end
                prev_valid = if_valid;
                if (imem_req && imem_ack) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
                    end else begin
                        pend_pc    = exp_addr_q.pop_front();
                        pend_instr = exp_instr_q.pop_front();
                        chk("fetch_addr", imem_addr, pend_pc);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!if_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!if_valid) chk("wait_valid_timeout", {31'd0, if_valid}, 32'd1);
    endtask

    task automatic retire_one(input logic [1:0] op, input logic [31:0] rs,
                              input logic do_push, input logic [31:0] nxt, input logic [31:0] ins);
        wait_valid();
        if (do_push) begin
            exp_addr_q.push_back(nxt);
            exp_instr_q.push_back(ins);
        end
        npc_op   = op;
        rs_data  = rs;
        if_ready = 1'b1;
        @(posedge clk);
        #1;
        if_ready = 1'b0;
    endtask

    initial begin
        rstn     = 1'b0;
        imem_ack = 1'b1;
        if_ready = 1'b0;
        npc_op   = 2'b00;
        rs_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);

        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back(32'h2008_0005);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("c1_imem_req", {31'd0, imem_req}, 32'd1);
        chk("c1_if_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("c2_if_valid", {31'd0, if_valid}, 32'd1);

        imem_ack = 1'b0;
        retire_one(2'b00, 32'h0, 1'b1, 32'h0000_0004, 32'h2009_0007);
        chk("retire_cnt_1", retire_cnt, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, 32'h0000_0004);
            chk("stall_valid", {31'd0, if_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b1;

        retire_one(2'b11, 32'h0000_0010, 1'b1, 32'h0000_0010, 32'h1000_FFFE);
        retire_one(2'b01, 32'h0,         1'b1, 32'h0000_000C, 32'h2010_000C);
        retire_one(2'b11, 32'h0000_0010, 1'b1, 32'h0000_0010, 32'h1000_FFFE);
        retire_one(2'b00, 32'h0,         1'b1, 32'h0000_0014, 32'h2014_0014);
        retire_one(2'b11, 32'hF000_0000, 1'b1, 32'hF000_0000, 32'h0800_0040);
        retire_one(2'b10, 32'h0,         1'b1, 32'hF000_0100, 32'h0000_0008);
        retire_one(2'b11, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0009);

        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, 32'h0000_0200);
            chk("hold_instr", if_instr, 32'h0000_0009);
            chk("hold_no_req", {31'd0, imem_req}, 32'd0);
        end

        retire_one(2'b11, 32'h0000_0202, 1'b0, 32'h0, 32'h0);
        chk("err_flag", {31'd0, fetch_err}, 32'd1);
        chk("err_req", {31'd0, imem_req}, 32'd0);
        chk("err_valid", {31'd0, if_valid}, 32'd0);
        chk("err_addr", imem_addr, 32'h0000_0202);
        chk("err_retire_cnt", retire_cnt, 32'd9);
        if_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if_ready = 1'b0;
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("err_sticky_cnt", retire_cnt, 32'd9);
        chk("queue_drained", exp_addr_q.size(), 32'd0);

        rstn = 1'b0;
        #1;
        chk("rst2_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst2_addr", imem_addr, 32'd0);
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midfetch_req", {31'd0, imem_req}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_valid", {31'd0, if_valid}, 32'd0);
        chk("async_cnt", retire_cnt, 32'd0);
        chk("async_if_pc", if_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
